// File: rtl/ad_capture_writer.sv
// ADC capture write initiator: packs strobed four-channel sample sets into 16-bit words
// and streams them into PSRAM as fixed-length AXI4-style write bursts, one outstanding at a time.
module ad_capture_writer #(
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [24:0] base_addr,
    input  logic [15:0] num_bursts,
    input  logic        psram_ready,
    input  logic [11:0] ad_a0,
    input  logic [11:0] ad_a1,
    input  logic [11:0] ad_b0,
    input  logic [11:0] ad_b1,
    input  logic        ad_strobe,
    output logic [24:0] awaddr,
    output logic [7:0]  awlen,
    output logic        awvalid,
    input  logic        awready,
    output logic [15:0] wdata,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready,
    output logic        busy,
    output logic        done,
    output logic [15:0] overflow_cnt,
    output logic        resp_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam logic [LVL_W-1:0]  LVL_BURST   = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]  LVL_FULL    = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LVL_SET_MAX = LVL_W'(FIFO_DEPTH - 4);
    localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ADDR, S_DATA, S_RESP, S_FIN} state_t;

    state_t              state_q, state_d;
    logic                awvalid_q, awvalid_d;
    logic [24:0]         awaddr_q, awaddr_d;
    logic [15:0]         remain_q, remain_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [15:0]         ovf_q, ovf_d;
    logic                err_q, err_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                pack_act_q, pack_act_d;
    logic [1:0]          pack_ch_q, pack_ch_d;
    logic [11:0]         samp_q [4];
    logic [11:0]         samp_d [4];
    logic [15:0]         mem_q [FIFO_DEPTH];

    logic                busy_w, push_w, pop_w, strobe_acc, strobe_drop;
    logic [15:0]         push_word;

    always_comb begin
        busy_w      = (state_q == S_FILL) || (state_q == S_ADDR) ||
                      (state_q == S_DATA) || (state_q == S_RESP);
        push_w      = pack_act_q && (state_q != S_FIN);
        pop_w       = (state_q == S_DATA) && wready;
        push_word   = {2'b00, pack_ch_q, samp_q[pack_ch_q]};
        // A set is only taken when the packer is idle and all four words are guaranteed room.
        strobe_acc  = busy_w && ad_strobe && !pack_act_q && (level_q <= LVL_SET_MAX);
        strobe_drop = busy_w && ad_strobe && !strobe_acc;
    end

    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        awaddr_d   = awaddr_q;
        remain_d   = remain_q;
        beat_d     = beat_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_w);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_w);
        level_d    = level_q + LVL_W'(push_w) - LVL_W'(pop_w);
        pack_act_d = pack_act_q;
        pack_ch_d  = pack_ch_q;
        samp_d     = samp_q;

        if (pack_act_q) begin
            pack_ch_d = pack_ch_q + 2'd1;
            if (pack_ch_q == 2'd3) pack_act_d = 1'b0;
        end
        if (strobe_acc) begin
            samp_d     = '{ad_a0, ad_a1, ad_b0, ad_b1};
            pack_act_d = 1'b1;
            pack_ch_d  = 2'd0;
        end
        if (strobe_drop && (ovf_q != '1)) ovf_d = ovf_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    awaddr_d = base_addr;
                    remain_d = num_bursts;
                    ovf_d    = '0;
                    err_d    = 1'b0;
                    state_d  = (num_bursts == '0) ? S_FIN : S_FILL;
                end
            end
            S_FILL: begin
                if ((level_q >= LVL_BURST) && psram_ready) begin
                    awvalid_d = 1'b1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (awready) begin
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (wready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_LAST) state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bvalid) begin
                    if (bresp != 2'b00) err_d = 1'b1;
                    remain_d = remain_q - 16'd1;
                    awaddr_d = awaddr_q + 25'(BURST_LEN);
                    state_d  = (remain_q == 16'd1) ? S_FIN : S_FILL;
                end
            end
            S_FIN: begin
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                level_d    = '0;
                pack_act_d = 1'b0;
                pack_ch_d  = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            awvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            remain_q   <= '0;
            beat_q     <= '0;
            ovf_q      <= '0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pack_act_q <= 1'b0;
            pack_ch_q  <= '0;
            samp_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            awaddr_q   <= awaddr_d;
            remain_q   <= remain_d;
            beat_q     <= beat_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pack_act_q <= pack_act_d;
            pack_ch_q  <= pack_ch_d;
            samp_q     <= samp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_w) mem_q[wr_ptr_q] <= push_word;
    end

    assign awaddr       = awaddr_q;
    assign awlen        = 8'(BURST_LEN);
    assign awvalid      = awvalid_q;
    assign wvalid       = (state_q == S_DATA);
    assign wdata        = wvalid ? mem_q[rd_ptr_q] : '0;
    assign bready       = 1'b1;
    assign busy         = busy_w;
    assign done         = (state_q == S_FIN);
    assign overflow_cnt = ovf_q;
    assign resp_err     = err_q;

    assert property (@(posedge clk) disable iff (!reset_n) !(push_w && !pop_w && (level_q == LVL_FULL)));
    assert property (@(posedge clk) disable iff (!reset_n) !(pop_w && (level_q == '0)));

endmodule

// File: tb/tb_ad_capture_writer.sv
// Bench for ad_capture_writer: scenario table plus randomized runs, checked cycle by cycle
// against a transaction-level model (word queue, drop rules, address arithmetic).
module tb_ad_capture_writer;

    localparam int BL    = 8;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset_n, start, psram_ready, ad_strobe, awready, wready, bvalid;
    logic [24:0] base_addr;
    logic [15:0] num_bursts;
    logic [11:0] ad_a0, ad_a1, ad_b0, ad_b1;
    logic [1:0]  bresp;
    logic [24:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid, wvalid, bready, busy, done, resp_err;
    logic [15:0] wdata, overflow_cnt;

    ad_capture_writer #(.BURST_LEN(BL), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_bursts(num_bursts), .psram_ready(psram_ready),
        .ad_a0(ad_a0), .ad_a1(ad_a1), .ad_b0(ad_b0), .ad_b1(ad_b1), .ad_strobe(ad_strobe),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .busy(busy), .done(done), .overflow_cnt(overflow_cnt), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] base;
        int          nb;
        int          period;
        int          fixed;
        int          aw_delay;   // -1: random awready
        int          wr_mode;    // 0 always, 1 toggle, 2 stalled for 200 cycles, 3 random
        int          ps_rand;
        int          b_rand;
        int          err_burst;  // -1: never
        int          rst_mid;
        int          exp_aw;
        logic [24:0] exp_last;
        logic        exp_err;
        int          exp_ovf_nz;
    } scen_t;

    int checks = 0;
    int failures = 0;

    scen_t       cur;
    scen_t       tbl [12];
    logic [15:0] q [$];
    logic [11:0] smp_m [4];
    logic [11:0] smp_drv [4];
    int          pend, beats, bursts_left, run_cyc, aw_wait, b_wait, aw_cnt, done_cnt, nb_m;
    logic        run_active, in_data, fill_phase, b_pend, done_next, finished, aborted;
    logic        start_req, exp_busy, exp_done, exp_awv, exp_wv, err_m;
    logic [24:0] exp_addr, last_addr, req_base;
    logic [15:0] req_nb, ovf_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input int ch, input logic [11:0] s);
        logic [1:0] c;
        c = ch[1:0];
        return {2'b00, c, s};
    endfunction

    function automatic scen_t mk(input logic [24:0] base, input int nb, input int period,
                                 input int fixed, input int aw_delay, input int wr_mode,
                                 input int ps_rand, input int b_rand, input int err_burst,
                                 input int rst_mid, input logic [24:0] exp_last,
                                 input int exp_ovf_nz);
        scen_t s;
        s.base = base; s.nb = nb; s.period = period; s.fixed = fixed;
        s.aw_delay = aw_delay; s.wr_mode = wr_mode; s.ps_rand = ps_rand; s.b_rand = b_rand;
        s.err_burst = err_burst; s.rst_mid = rst_mid; s.exp_aw = nb;
        s.exp_last = exp_last; s.exp_err = (err_burst >= 0); s.exp_ovf_nz = exp_ovf_nz;
        return s;
    endfunction

    task automatic model_reset();
        q.delete();
        pend = 0; beats = 0; bursts_left = 0; aw_wait = 0; b_wait = 0;
        run_active = 0; in_data = 0; fill_phase = 0; b_pend = 0; done_next = 0;
        start_req = 0; exp_busy = 0; exp_done = 0; exp_awv = 0; exp_wv = 0;
        err_m = 0; ovf_m = '0; exp_addr = '0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_awvalid", awvalid, 0);   chk("rst_wvalid", wvalid, 0);
        chk("rst_awaddr", awaddr, 0);     chk("rst_wdata", wdata, 0);
        chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
        chk("rst_overflow_cnt", overflow_cnt, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_awlen", awlen, BL);      chk("rst_bready", bready, 1);
    endtask

    task automatic step();
        int   qs0, pend0;
        logic acc, refill, due;
        // Observe outputs for the cycle just begun.
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("awvalid", awvalid, exp_awv);
        chk("wvalid", wvalid, exp_wv);
        if (awvalid) chk("awaddr", awaddr, exp_addr);
        chk("awlen", awlen, BL);
        chk("bready", bready, 1);
        chk("overflow_cnt", overflow_cnt, ovf_m);
        chk("resp_err", resp_err, err_m);
        if (done) done_cnt++;

        // Drive inputs for the coming edge.
        start      = 1'b0;
        base_addr  = 25'($urandom);
        num_bursts = 16'($urandom);
        if (start_req) begin
            start = 1'b1; base_addr = req_base; num_bursts = req_nb;
        end else if (run_active && run_cyc == 25) begin
            start = 1'b1;
        end
        ad_strobe = ((run_cyc % cur.period) == 0);
        for (int i = 0; i < 4; i++) smp_drv[i] = 12'($urandom);
        if (cur.fixed != 0) smp_drv = '{12'h123, 12'h456, 12'h789, 12'hABC};
        ad_a0 = smp_drv[0]; ad_a1 = smp_drv[1]; ad_b0 = smp_drv[2]; ad_b1 = smp_drv[3];
        psram_ready = (cur.ps_rand != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (awvalid) aw_wait++; else aw_wait = 0;
        if (!awvalid)           awready = 1'($urandom);
        else if (cur.aw_delay < 0) awready = 1'($urandom);
        else                    awready = (aw_wait > cur.aw_delay);
        case (cur.wr_mode)
            0:       wready = 1'b1;
            1:       wready = run_cyc[0];
            2:       wready = (run_cyc >= 200);
            default: wready = 1'($urandom);
        endcase
        bvalid = 1'b0;
        bresp  = 2'($urandom);
        if (b_pend) begin
            if (b_wait == 0) begin
                bvalid = 1'b1;
                bresp  = ((nb_m - bursts_left) == cur.err_burst) ? 2'b10 : 2'b00;
                b_pend = 0;
            end else b_wait--;
        end

        // Model the effect of the coming edge.
        qs0 = q.size(); pend0 = pend; acc = 0; refill = 0;
        if (ad_strobe && run_active) begin
            if (pend0 > 0 || (DEPTH - qs0) < 4) ovf_m = (ovf_m == 16'hFFFF) ? ovf_m : ovf_m + 16'd1;
            else acc = 1;
        end
        if (wvalid && wready) begin
            if (q.size() == 0) chk("w_underflow", q.size(), 1);
            else begin
                chk("wdata", wdata, q[0]);
                void'(q.pop_front());
            end
            beats++;
            if (beats == BL) begin
                in_data = 0; b_pend = 1;
                b_wait = (cur.b_rand != 0) ? $urandom_range(0, 3) : 0;
            end
        end
        if (pend0 > 0) begin
            q.push_back(word_of(4 - pend0, smp_m[4 - pend0]));
            pend = pend0 - 1;
        end
        if (acc) begin
            pend = 4; smp_m = smp_drv;
        end
        if (awvalid && awready) begin
            chk("aw_level_ge_burst", (qs0 >= BL), 1);
            aw_cnt++; last_addr = awaddr; in_data = 1; beats = 0;
        end
        if (bvalid) begin
            if (bresp != 2'b00) err_m = 1;
            bursts_left--;
            exp_addr = exp_addr + 25'(BL);
            if (bursts_left == 0) begin
                run_active = 0; done_next = 1; finished = 1; q.delete(); pend = 0;
            end else refill = 1;
        end
        if (start_req) begin
            start_req = 0; nb_m = int'(req_nb); bursts_left = nb_m;
            exp_addr = req_base; ovf_m = '0; err_m = 0;
            run_active = (req_nb != 0); done_next = (req_nb == 0);
            refill = (req_nb != 0); finished = (req_nb == 0);
        end

        due = fill_phase && (qs0 >= BL) && psram_ready;
        if (due) fill_phase = 0;
        if (refill) fill_phase = 1;
        exp_awv  = (awvalid && !awready) || due;
        exp_wv   = in_data;
        exp_busy = run_active;
        exp_done = done_next;
        done_next = 0;

        @(posedge clk);
        #1;
        run_cyc++;
    endtask

    task automatic do_mid_reset();
        reset_n = 1'b0; start = 1'b0; ad_strobe = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        aborted = 1;
    endtask

    task automatic run_scen(input scen_t s);
        int guard;
        cur = s; run_cyc = 0; aw_cnt = 0; done_cnt = 0;
        finished = 0; aborted = 0; last_addr = '0;
        repeat (2) step();
        start_req = 1; req_base = s.base; req_nb = 16'(s.nb);
        guard = 0;
        while (!finished && !aborted && guard < 8000) begin
            if (s.rst_mid != 0 && in_data && beats >= 2) do_mid_reset();
            else step();
            guard++;
        end
        if (!finished && !aborted) chk("run_timeout", finished, 1);
        if (!aborted) begin
            repeat (4) step();
            chk("aw_count", aw_cnt, s.exp_aw);
            if (s.exp_aw > 0) chk("last_awaddr", last_addr, s.exp_last);
            chk("done_count", done_cnt, 1);
            chk("resp_err_final", resp_err, s.exp_err);
            if (s.exp_ovf_nz != 0) chk("overflow_nonzero", (overflow_cnt != 0), 1);
        end
    endtask

    initial begin
        int nb, eb;
        logic [24:0] b;
        tbl[0] = mk(25'h0000100, 2, 16, 1,  0, 0, 0, 0, -1, 0, 25'h0000108, 0);
        tbl[1] = mk(25'h0002000, 3, 10, 0,  5, 1, 0, 0, -1, 0, 25'h0002010, 0);
        tbl[2] = mk(25'h0000040, 3,  8, 0,  0, 2, 0, 0, -1, 0, 25'h0000050, 1);
        tbl[3] = mk(25'h0000777, 0,  6, 0,  0, 0, 0, 0, -1, 0, 25'h0000000, 0);
        tbl[4] = mk(25'h0000300, 2,  7, 0,  0, 0, 0, 1,  0, 0, 25'h0000308, 0);
        tbl[5] = mk(25'h1FFFFFC, 2,  9, 0,  0, 0, 0, 0, -1, 0, 25'h0000004, 0);
        tbl[6] = mk(25'h0005000, 2,  5, 0,  0, 1, 0, 0, -1, 1, 25'h0005008, 0);
        tbl[7] = mk(25'h0ABCDE0, 2,  6, 0, -1, 3, 1, 1, -1, 0, 25'h0ABCDE8, 0);
        for (int r = 8; r < 12; r++) begin
            b  = 25'($urandom);
            nb = $urandom_range(1, 4);
            eb = $urandom_range(0, nb);
            tbl[r] = mk(b, nb, $urandom_range(4, 20), 0, -1, 3, 1, 1,
                        (eb == nb) ? -1 : eb, 0, b + 25'(BL * (nb - 1)), 0);
        end

        reset_n = 1'b0; start = 1'b0; psram_ready = 1'b1; ad_strobe = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        base_addr = '0; num_bursts = '0;
        ad_a0 = '0; ad_a1 = '0; ad_b0 = '0; ad_b1 = '0;
        model_reset();
        cur = tbl[0];
        #2;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) run_scen(tbl[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/ad_capture_writer.md
Name: ad_capture_writer

Overview:
- AXI4-style write initiator that streams ADC sample sets into PSRAM through the psram_ctrl write port (wdata/awaddr/bvalid), which currently has no driver.
- Write-side counterpart of the video2 read path; one run fills a linear PSRAM region that video2 can later replay.
- Sits in the clk (48 MHz) domain next to blaster, consuming ad_a0/ad_a1/ad_b0/ad_b1/ad_strobe.

Parameters:
- BURST_LEN, 8, beats per write burst; also the value driven on awlen and the awaddr increment.
- FIFO_DEPTH, 32, 16-bit word FIFO depth; power of 2, at least 2*BURST_LEN.

Ports:
- clk  in  1  48 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a capture run; ignored while busy=1.
- base_addr  in  25  first burst address, sampled on start.
- num_bursts  in  16  bursts per run, sampled on start; 0 means finish immediately.
- psram_ready  in  1  controller ready; no AW is issued while it is 0.
- ad_a0, ad_a1, ad_b0, ad_b1  in  12 each  ADC samples.
- ad_strobe  in  1  one-cycle pulse marking the four ADC samples valid.
- awaddr  out  25  burst address.
- awlen  out  8  constant BURST_LEN.
- awvalid  out  1  write-address valid.
- awready  in  1  write-address accepted.
- wdata  out  16  write data.
- wvalid  out  1  write-data valid.
- wready  in  1  write-data accepted.
- bvalid  in  1  write-response valid.
- bresp  in  2  write-response code.
- bready  out  1  constant 1.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run completes.
- overflow_cnt  out  16  dropped sample sets, saturating.
- resp_err  out  1  sticky flag: a bresp other than 0 was seen.

Behaviour:
- Reset (asynchronous assert, release on clk): FSM=IDLE, FIFO empty, awvalid=0, wvalid=0, awaddr=0, wdata=0, busy=0, done=0, overflow_cnt=0, resp_err=0. awlen=BURST_LEN and bready=1 at all times.
- Word packing: {2'b00, ch[1:0], sample[11:0]}, with ch 0=a0, 1=a1, 2=b0, 3=b1.
- Packer:
  - While busy=1, ad_strobe latches all four samples, then pushes one word per cycle in ch order 0..3, starting the cycle after the strobe.
  - A strobe is dropped and overflow_cnt incremented (stopping at 0xFFFF) if either the packer is still pushing, or FIFO free space is below 4 at the strobe.
  - A sample set is never split.
  - Strobes while busy=0 are ignored and not counted.
- FIFO: synchronous, single clock. A push and a pop in the same cycle are both performed and the level is unchanged. The FIFO is emptied when a run completes.
- FSM states:
  - IDLE: busy=0. On start, latch base_addr into awaddr and num_bursts into the remaining count, set busy=1. If num_bursts=0, go to FIN; otherwise go to FILL.
  - FILL: when FIFO level >= BURST_LEN and psram_ready=1, assert awvalid and go to ADDR.
  - ADDR: hold awvalid and awaddr stable until awready. On the cycle awready=1, drop awvalid next cycle, go to DATA, beat count=0.
  - DATA: wvalid=1 and wdata=FIFO head. Each cycle with wvalid&wready pops the FIFO and counts a beat. wvalid stays high back-to-back and deasserts the cycle after beat BURST_LEN. wdata is stable while wvalid&!wready. Then go to RESP.
  - RESP: wait for bvalid. If bresp!=0, set resp_err. Decrement remaining, add BURST_LEN to awaddr (25-bit wrap, no carry out). If remaining becomes 0 go to FIN, else go to FILL.
  - FIN: done=1 for exactly one cycle, busy=0, flush the FIFO and packer, then go to IDLE.
- Only one burst outstanding at a time: the next AW is issued only after the previous bvalid.
- start while busy=1 is ignored.
- overflow_cnt and resp_err clear only on reset or on an accepted start.
- Latency: the earliest awvalid is 1 cycle after the FIFO level reaches BURST_LEN.
- Assertions: the FIFO never over- or under-flows, and wvalid is never asserted outside DATA.

Test Plan:
- Basic run: base_addr=0x0000100, num_bursts=2, strobes every 16 cycles with a0..b1=0x123,0x456,0x789,0xABC; awready/wready/bvalid=1 with bresp=0 -> two AWs at 0x100 and 0x108, awlen=8; wdata sequence 0x0123,0x1456,0x2789,0x3ABC repeating; a single done pulse; overflow_cnt=0.
- Backpressure: awready delayed 5 cycles, wready toggling 1/0 -> awaddr, awvalid and wdata held stable while stalled; exactly 8 beats are accepted per burst.
- Overflow: wready=0 for 200 cycles with strobes every 8 cycles -> FIFO level stays at or below 32; overflow_cnt counts the drops; no partial sample sets appear in wdata after wready is released.
- Corner cases, part 1: num_bursts=0 -> done pulse 1 cycle after the FSM leaves IDLE and no AW is issued. A start while busy=1 has no effect.
- Corner cases, part 2: bresp=2 on burst 1 -> resp_err=1 and the run still completes. base_addr=0x1FFFFFC -> the second burst is at 0x0000004 (wrap).
- Reset mid-burst: reset_n low during DATA -> all outputs at reset values immediately; after a new start, the run restarts cleanly from the new base_addr.
